// File: rtl/seletor_minigame.sv
// Menu controller in front of the minigame multiplexer: navigate, confirm, pulse start, wait for done.
// Optional MENU_TIMEOUT_EN: menu inactivity powers the controller back down after TIMEOUT_CICLOS cycles.
module seletor_minigame #(
  parameter int FIM_CICLOS     = 50_000_000,
  parameter int TIMEOUT_CICLOS = 500_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ligar,
  input  logic       proximo,
  input  logic       anterior,
  input  logic       confirma,
  input  logic       pronto,
  output logic [1:0] minigame,
  output logic [3:0] estado_inicial,
  output logic [2:0] inicia_jogo,
  output logic [1:0] destaque
);

  typedef enum logic [3:0] {
    DESLIGADO = 4'h0,
    MENU      = 4'h1,
    DISPARA   = 4'h2,
    JOGANDO   = 4'h3,
    FIM       = 4'hF
  } state_t;

  localparam int FIM_W = (FIM_CICLOS > 1) ? $clog2(FIM_CICLOS) : 1;
  localparam logic [FIM_W-1:0] FIM_LAST = FIM_W'(FIM_CICLOS - 1);

  state_t           state, state_next;
  logic [1:0]       sel, sel_next;
  logic             ligar_prev, proximo_prev, anterior_prev, confirma_prev;
  logic             ligar_edge, proximo_edge, anterior_edge, confirma_edge;
  logic [FIM_W-1:0] fim_cnt;
  logic             timeout_hit;
  logic [1:0]       minigame_next;
  logic [2:0]       inicia_next;
  logic [3:0]       estado_next;

  // Prev flops start high so a button held through reset needs a fresh press.
  always_ff @(posedge clock) begin
    if (reset) begin
      {ligar_prev, proximo_prev, anterior_prev, confirma_prev} <= 4'hF;
    end else begin
      {ligar_prev, proximo_prev, anterior_prev, confirma_prev} <=
        {ligar, proximo, anterior, confirma};
    end
  end

  assign ligar_edge    = ligar    & ~ligar_prev;
  assign proximo_edge  = proximo  & ~proximo_prev;
  assign anterior_edge = anterior & ~anterior_prev;
  assign confirma_edge = confirma & ~confirma_prev;

`ifdef MENU_TIMEOUT_EN
  localparam logic [29:0] TO_LAST = 30'(TIMEOUT_CICLOS - 1);
  logic [29:0] to_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      to_cnt <= '0;
    end else if (state == MENU && state_next == MENU && !proximo_edge && !anterior_edge) begin
      to_cnt <= to_cnt + 30'd1;
    end else begin
      to_cnt <= '0;
    end
  end

  assign timeout_hit = (to_cnt == TO_LAST);
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CICLOS;
  assign timeout_hit    = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= DESLIGADO;
      sel   <= 2'd0;
    end else begin
      state <= state_next;
      sel   <= sel_next;
    end
  end

  always_comb begin
    state_next = state;
    sel_next   = sel;
    case (state)
      DESLIGADO: begin
        if (ligar_edge) begin
          state_next = MENU;
          sel_next   = 2'd0;
        end
      end
      MENU: begin
        // Confirm beats navigation; any navigation edge beats the timeout.
        if (confirma_edge) begin
          state_next = DISPARA;
        end else if (proximo_edge && !anterior_edge) begin
          sel_next = (sel == 2'd2) ? 2'd0 : sel + 2'd1;
        end else if (anterior_edge && !proximo_edge) begin
          sel_next = (sel == 2'd0) ? 2'd2 : sel - 2'd1;
        end else if (!proximo_edge && !anterior_edge && timeout_hit) begin
          state_next = DESLIGADO;
          sel_next   = 2'd0;
        end
      end
      DISPARA: state_next = JOGANDO;
      JOGANDO: begin
        if (pronto) state_next = FIM;
      end
      FIM: begin
        if (confirma_edge || fim_cnt == FIM_LAST) state_next = MENU;
      end
      default: state_next = DESLIGADO;
    endcase
  end

  // Counter is zero on FIM entry and cleared whenever FIM is left.
  always_ff @(posedge clock) begin
    if (reset) begin
      fim_cnt <= '0;
    end else if (state == FIM && state_next == FIM) begin
      fim_cnt <= fim_cnt + 1'b1;
    end else begin
      fim_cnt <= '0;
    end
  end

  always_comb begin
    minigame_next = 2'b11;
    inicia_next   = 3'b000;
    estado_next   = state_next;
    case (state_next)
      DISPARA: begin
        minigame_next = sel_next;
        inicia_next   = 3'b001 << sel_next;
      end
      JOGANDO: minigame_next = sel_next;
      default: minigame_next = 2'b11;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      minigame       <= 2'b11;
      estado_inicial <= 4'h0;
      inicia_jogo    <= 3'b000;
    end else begin
      minigame       <= minigame_next;
      estado_inicial <= estado_next;
      inicia_jogo    <= inicia_next;
    end
  end

  assign destaque = sel;

endmodule

// File: tb/tb_seletor_minigame.sv
// Self-checking bench for seletor_minigame: directed scenarios plus random buttons against a menu model.
module tb_seletor_minigame;

  localparam int FIM_N = 4;
  localparam int TO_N  = 8;

  logic       clock = 1'b0;
  logic       reset, ligar, proximo, anterior, confirma, pronto;
  logic [1:0] minigame;
  logic [3:0] estado_inicial;
  logic [2:0] inicia_jogo;
  logic [1:0] destaque;
  logic [10:0] obs;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: mode 0 off, 1 menu, 2 start pulse, 3 playing, 4 end screen.
  int m_mode = 0;
  int m_dest = 0;
  int m_fim  = 0;
`ifdef MENU_TIMEOUT_EN
  int m_to   = 0;
`endif
  logic [3:0] pv = 4'hF;

  seletor_minigame #(.FIM_CICLOS(FIM_N), .TIMEOUT_CICLOS(TO_N)) dut (
    .clock(clock), .reset(reset), .ligar(ligar), .proximo(proximo),
    .anterior(anterior), .confirma(confirma), .pronto(pronto),
    .minigame(minigame), .estado_inicial(estado_inicial),
    .inicia_jogo(inicia_jogo), .destaque(destaque)
  );

  assign obs = {minigame, estado_inicial, inicia_jogo, destaque};

  always #5 clock = ~clock;

  function automatic logic [10:0] expected();
    logic [1:0] mg;
    logic [3:0] est;
    logic [2:0] ini;
    mg  = (m_mode == 2 || m_mode == 3) ? 2'(m_dest) : 2'b11;
    ini = (m_mode == 2) ? 3'(1 << m_dest) : 3'b000;
    case (m_mode)
      1: est = 4'h1;
      2: est = 4'h2;
      3: est = 4'h3;
      4: est = 4'hF;
      default: est = 4'h0;
    endcase
    return {mg, est, ini, 2'(m_dest)};
  endfunction

  task automatic model_step();
    logic el, ep, ea, ec;
    if (reset) begin
      m_mode = 0; m_dest = 0; m_fim = 0; pv = 4'hF;
`ifdef MENU_TIMEOUT_EN
      m_to = 0;
`endif
      return;
    end
    el = ligar & ~pv[3];
    ep = proximo & ~pv[2];
    ea = anterior & ~pv[1];
    ec = confirma & ~pv[0];
    pv = {ligar, proximo, anterior, confirma};
    case (m_mode)
      0: if (el) begin m_mode = 1; m_dest = 0; end
      1: begin
        if (ec) m_mode = 2;
        else if (ep && !ea) m_dest = (m_dest + 1) % 3;
        else if (ea && !ep) m_dest = (m_dest + 2) % 3;
`ifdef MENU_TIMEOUT_EN
        if (ec || ep || ea) m_to = 0;
        else if (m_to == TO_N - 1) begin m_mode = 0; m_dest = 0; end
        else m_to++;
`endif
      end
      2: m_mode = 3;
      3: if (pronto) begin m_mode = 4; m_fim = 0; end
      default: begin
        if (ec || m_fim == FIM_N - 1) m_mode = 1;
        else m_fim++;
      end
    endcase
    if (m_mode != 4) m_fim = 0;
`ifdef MENU_TIMEOUT_EN
    if (m_mode != 1) m_to = 0;
`endif
  endtask

  task automatic drive(input logic l, input logic p, input logic a, input logic c, input logic pr);
    ligar = l; proximo = p; anterior = a; confirma = c; pronto = pr;
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1, 1, 1, 1, 1);
    tick(); tick();
    n_cmp++;
    if (obs !== 11'b11_0000_000_00) begin
      n_bad++; $display("FAIL reset_values: got %h want %h", obs, 11'b11_0000_000_00);
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (estado_inicial !== 4'h0) begin
        n_bad++; $display("FAIL held_ligar_no_edge: estado %h want 0", estado_inicial);
      end
    end
    drive(0, 0, 0, 0, 0);
    tick();
    n_cmp++;
    if (obs !== expected()) begin
      n_bad++; $display("FAIL released_model: got %h want %h", obs, expected());
    end
    ligar = 1'b1;
    tick();
    n_cmp++;
    if (obs !== 11'b11_0001_000_00) begin
      n_bad++; $display("FAIL ligar_menu: got %h want %h", obs, 11'b11_0001_000_00);
    end
    ligar = 1'b0;
    tick();
  endtask

  task automatic test_navigation();
    int seq [4] = '{1, 2, 0, 2};
    for (int i = 0; i < 4; i++) begin
      drive(0, i < 3, i == 3, 0, 0);
      tick();
      n_cmp++;
      if (destaque !== 2'(seq[i]) || minigame !== 2'b11) begin
        n_bad++; $display("FAIL nav_step%0d: destaque %0d minigame %b want %0d 11", i, destaque, minigame, seq[i]);
      end
      drive(0, 0, 0, 0, 0);
      tick();
    end
    drive(0, 1, 1, 0, 0);
    tick();
    n_cmp++;
    if (destaque !== 2'd2 || estado_inicial !== 4'h1) begin
      n_bad++; $display("FAIL nav_both: destaque %0d estado %h want 2 1", destaque, estado_inicial);
    end
    drive(0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_start();
    confirma = 1'b1;
    tick();
    n_cmp++;
    if (obs !== 11'b10_0010_100_10) begin
      n_bad++; $display("FAIL dispara: got %h want %h", obs, 11'b10_0010_100_10);
    end
    confirma = 1'b0;
    tick();
    n_cmp++;
    if (obs !== 11'b10_0011_000_10) begin
      n_bad++; $display("FAIL jogando: got %h want %h", obs, 11'b10_0011_000_10);
    end
    drive(0, 1, 0, 1, 0);
    tick();
    n_cmp++;
    if (obs !== 11'b10_0011_000_10) begin
      n_bad++; $display("FAIL jogando_ignores_btn: got %h want %h", obs, 11'b10_0011_000_10);
    end
    drive(0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_fim_auto();
    pronto = 1'b1;
    tick();
    n_cmp++;
    if (obs !== 11'b11_1111_000_10) begin
      n_bad++; $display("FAIL fim_entry: got %h want %h", obs, 11'b11_1111_000_10);
    end
    pronto = 1'b0;
    for (int k = 0; k < FIM_N - 1; k++) begin
      tick();
      n_cmp++;
      if (estado_inicial !== 4'hF) begin
        n_bad++; $display("FAIL fim_hold%0d: estado %h want f", k, estado_inicial);
      end
    end
    tick();
    n_cmp++;
    if (obs !== 11'b11_0001_000_10) begin
      n_bad++; $display("FAIL fim_auto_return: got %h want %h", obs, 11'b11_0001_000_10);
    end
  endtask

  task automatic test_fim_confirma();
    confirma = 1'b1; tick();
    confirma = 1'b0; tick();
    pronto = 1'b1; tick();
    pronto = 1'b0; tick();
    n_cmp++;
    if (estado_inicial !== 4'hF) begin
      n_bad++; $display("FAIL fim_before_confirma: estado %h want f", estado_inicial);
    end
    confirma = 1'b1;
    tick();
    n_cmp++;
    if (obs !== 11'b11_0001_000_10) begin
      n_bad++; $display("FAIL fim_confirma: got %h want %h", obs, 11'b11_0001_000_10);
    end
    confirma = 1'b0;
    tick();
  endtask

  task automatic test_reset_midgame();
    confirma = 1'b1; tick();
    confirma = 1'b0; tick();
    n_cmp++;
    if (estado_inicial !== 4'h3) begin
      n_bad++; $display("FAIL midgame_playing: estado %h want 3", estado_inicial);
    end
    reset = 1'b1;
    tick();
    n_cmp++;
    if (obs !== 11'b11_0000_000_00) begin
      n_bad++; $display("FAIL reset_midgame: got %h want %h", obs, 11'b11_0000_000_00);
    end
    reset = 1'b0;
    tick();
    n_cmp++;
    if (obs !== expected()) begin
      n_bad++; $display("FAIL after_reset_model: got %h want %h", obs, expected());
    end
  endtask

`ifdef MENU_TIMEOUT_EN
  task automatic test_timeout();
    ligar = 1'b1; tick();
    ligar = 1'b0;
    for (int i = 0; i < TO_N - 1; i++) begin
      tick();
      n_cmp++;
      if (estado_inicial !== 4'h1) begin
        n_bad++; $display("FAIL idle_menu%0d: estado %h want 1", i, estado_inicial);
      end
    end
    tick();
    n_cmp++;
    if (estado_inicial !== 4'h0 || destaque !== 2'd0) begin
      n_bad++; $display("FAIL timeout_off: estado %h destaque %0d want 0 0", estado_inicial, destaque);
    end
    ligar = 1'b1; tick();
    ligar = 1'b0;
    repeat (TO_N - 1) tick();
    proximo = 1'b1;
    tick();
    n_cmp++;
    if (estado_inicial !== 4'h1 || destaque !== 2'd1) begin
      n_bad++; $display("FAIL timeout_btn_wins: estado %h destaque %0d want 1 1", estado_inicial, destaque);
    end
    proximo = 1'b0;
    repeat (TO_N - 1) tick();
    n_cmp++;
    if (estado_inicial !== 4'h1) begin
      n_bad++; $display("FAIL timeout_restart: estado %h want 1", estado_inicial);
    end
    tick();
    n_cmp++;
    if (estado_inicial !== 4'h0) begin
      n_bad++; $display("FAIL timeout_second: estado %h want 0", estado_inicial);
    end
  endtask
`endif

  task automatic test_random();
    reset = 1'b1;
    drive(0, 0, 0, 0, 0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 299) == 0);
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0);
      tick();
      n_cmp++;
      if (obs !== expected()) begin
        n_bad++; $display("FAIL random_%0d: got %h want %h", i, obs, expected());
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0);
    test_reset();
    test_navigation();
    test_start();
    test_fim_auto();
    test_fim_confirma();
    test_reset_midgame();
`ifdef MENU_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
